// File: rtl/spc_case_pipe_if.sv
// spc_case_pipe_if -- operand/result bundle for the FP special-case pipeline.
//   master : operand source + result sink (drives in_valid/op/a/b, out_ready, cnt_clr)
//   slave  : the pipeline itself (drives in_ready, out_valid, res, s_case, flags, spc_cnt)
//   W = E_WIDTH + M_WIDTH + 1, raw IEEE {sign, biased exp, fraction}.
interface spc_case_pipe_if #(
  parameter int E_WIDTH   = 8,
  parameter int M_WIDTH   = 23,
  parameter int CNT_WIDTH = 16
);
  localparam int W = E_WIDTH + M_WIDTH + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           op;
  logic [W-1:0]         a;
  logic [W-1:0]         b;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         res;
  logic                 s_case;
  logic                 flg_inv;
  logic                 flg_inf;
  logic                 flg_zero;
  logic [CNT_WIDTH-1:0] spc_cnt;
  logic                 cnt_clr;

  modport master (
    output in_valid, op, a, b, out_ready, cnt_clr,
    input  in_ready, out_valid, res, s_case, flg_inv, flg_inf, flg_zero, spc_cnt
  );

  modport slave (
    input  in_valid, op, a, b, out_ready, cnt_clr,
    output in_ready, out_valid, res, s_case, flg_inv, flg_inf, flg_zero, spc_cnt
  );
endinterface

// File: rtl/spc_case_pipe.sv
// spc_case_pipe -- 2-stage IEEE-754 special-case detector for the add/sub/mul datapath.
// Classifies raw operands (NaN/sNaN/Inf/Zero, subnormal flushed when FTZ=1) and produces
// the bypass result plus exception flags; s_case=1 tells the result mux to skip the core.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low
//   bus   : spc_case_pipe_if.slave
//           in_valid/in_ready/op/a/b     operand beat (op: 00 add, 01 sub, 10 mul, 11 rsvd)
//           out_valid/out_ready          result handshake
//           res/s_case/flg_inv/inf/zero  result (res all-zero when s_case=0)
//           spc_cnt/cnt_clr              saturating count of delivered special beats
module spc_case_pipe #(
  parameter int E_WIDTH   = 8,
  parameter int M_WIDTH   = 23,
  parameter int FTZ       = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  spc_case_pipe_if.slave bus
);
  localparam int W = E_WIDTH + M_WIDTH + 1;
  localparam logic [E_WIDTH-1:0] EMAX = '1;
  localparam logic [W-1:0] QN = {1'b0, EMAX, 1'b1, {(M_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
  } cls_t;

  // S1 payload: classes, signs (sb already sign-flipped for sub), op and raw operands
  typedef struct packed {
    cls_t         ca;
    cls_t         cb;
    logic         sa;
    logic         sb;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         s_case;
    logic         inv;
    logic         inf;
    logic         zero;
  } s2_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    cls_t                 c;
    logic [E_WIDTH-1:0]   e;
    logic [M_WIDTH-1:0]   f;
    e      = x[W-2:M_WIDTH];
    f      = x[M_WIDTH-1:0];
    c.nan  = (e == EMAX) && (f != '0);
    c.snan = c.nan && !f[M_WIDTH-1];
    c.inf  = (e == EMAX) && (f == '0);
    // with FTZ a subnormal (exp 0, frac != 0) behaves exactly like a signed zero
    c.zero = (e == '0) && ((f == '0) || (FTZ != 0));
    return c;
  endfunction

  // pipeline valid bits: [0] = S1, [1] = S2
  logic [1:0] vld_pipe;
  logic       en1, en2;
  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // a stage advances when it is empty or the stage below is moving
  assign en2          = ~vld_pipe[1] | bus.out_ready;
  assign en1          = ~vld_pipe[0] | en2;
  assign bus.in_ready = en1;

  // ---- stage 1: classify ----
  always_comb begin
    s1_d    = '0;
    s1_d.ca = classify(bus.a);
    s1_d.cb = classify(bus.b);
    s1_d.sa = bus.a[W-1];
    s1_d.sb = bus.b[W-1] ^ (bus.op == 2'b01);
    s1_d.op = bus.op;
    s1_d.a  = bus.a;
    s1_d.b  = bus.b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[0] <= 1'b0;
      s1_q        <= '0;
    end else if (en1) begin
      vld_pipe[0] <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  // ---- stage 2: priority resolve ----
  // Empty S1 resolves to all-zero so an idle S2 never shows stale data.
  always_comb begin
    s2_d = '0;
    if (vld_pipe[0]) begin
      if (s1_q.op == 2'b11) begin
        s2_d.res = QN; s2_d.s_case = 1'b1; s2_d.inv = 1'b1;
      end else if (s1_q.ca.nan || s1_q.cb.nan) begin
        s2_d.res = QN; s2_d.s_case = 1'b1;
        s2_d.inv = s1_q.ca.snan || s1_q.cb.snan;
      end else if (s1_q.op == 2'b10) begin
        // multiply
        if ((s1_q.ca.inf && s1_q.cb.zero) || (s1_q.ca.zero && s1_q.cb.inf)) begin
          s2_d.res = QN; s2_d.s_case = 1'b1; s2_d.inv = 1'b1;
        end else if (s1_q.ca.inf || s1_q.cb.inf) begin
          s2_d.res    = {s1_q.sa ^ s1_q.sb, EMAX, {M_WIDTH{1'b0}}};
          s2_d.s_case = 1'b1; s2_d.inf = 1'b1;
        end else if (s1_q.ca.zero || s1_q.cb.zero) begin
          s2_d.res    = {s1_q.sa ^ s1_q.sb, {(W-1){1'b0}}};
          s2_d.s_case = 1'b1; s2_d.zero = 1'b1;
        end
      end else begin
        // add / sub, sb is the effective sign of B
        if (s1_q.ca.inf && s1_q.cb.inf && (s1_q.sa != s1_q.sb)) begin
          s2_d.res = QN; s2_d.s_case = 1'b1; s2_d.inv = 1'b1;
        end else if (s1_q.ca.inf) begin
          s2_d.res    = {s1_q.sa, EMAX, {M_WIDTH{1'b0}}};
          s2_d.s_case = 1'b1; s2_d.inf = 1'b1;
        end else if (s1_q.cb.inf) begin
          s2_d.res    = {s1_q.sb, EMAX, {M_WIDTH{1'b0}}};
          s2_d.s_case = 1'b1; s2_d.inf = 1'b1;
        end else if (s1_q.ca.zero && s1_q.cb.zero) begin
          s2_d.res    = {s1_q.sa & s1_q.sb, {(W-1){1'b0}}};
          s2_d.s_case = 1'b1; s2_d.zero = 1'b1;
        end else if (s1_q.ca.zero) begin
          s2_d.res    = {s1_q.sb, s1_q.b[W-2:0]};
          s2_d.s_case = 1'b1;
        end else if (s1_q.cb.zero) begin
          s2_d.res    = s1_q.a;
          s2_d.s_case = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[1] <= 1'b0;
      s2_q        <= '0;
    end else if (en2) begin
      vld_pipe[1] <= vld_pipe[0];
      s2_q        <= s2_d;
    end
  end

  // ---- special-case counter: clear wins over increment, sticks at all-ones ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (vld_pipe[1] && bus.out_ready && s2_q.s_case && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid = vld_pipe[1];
  assign bus.res       = s2_q.res;
  assign bus.s_case    = s2_q.s_case;
  assign bus.flg_inv   = s2_q.inv;
  assign bus.flg_inf   = s2_q.inf;
  assign bus.flg_zero  = s2_q.zero;
  assign bus.spc_cnt   = cnt_q;
endmodule

// File: tb/tb_spc_case_pipe.sv
// Directed bench for spc_case_pipe (E=8, M=23, FTZ=1, CNT_WIDTH=2).
// Driver pushes hand-computed expectations on accept; a negedge monitor pops and compares
// on each delivered beat, checks stall stability and tracks a reference event counter.
module tb_spc_case_pipe;
  localparam int EW = 8, MW = 23, CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spc_case_pipe_if #(.E_WIDTH(EW), .M_WIDTH(MW), .CNT_WIDTH(CW)) bus ();
  spc_case_pipe #(.E_WIDTH(EW), .M_WIDTH(MW), .FTZ(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // f = {s_case, inv, inf, zero}
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", n, act, req, $time);
    end
  endtask

  // called at posedge+#1; returns at posedge+#1 of the accept edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [31:0] r, input logic [3:0] f);
    logic rdy;
    bit   done;
    done = 0;
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.op = op;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        exp_q.push_back({r, f});
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout a=%h b=%h op=%b never accepted", a, b, op);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---- monitor ----
  logic [1:0]  mcnt;
  logic [35:0] held;
  bit          held_v;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      mcnt   = '0;
      held_v = 0;
    end else begin
      chk("spc_cnt", 64'(bus.spc_cnt), 64'(mcnt));
      if (bus.out_valid && bus.out_ready) begin
        held_v = 0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat got res=%h expected no beat", bus.res);
        end else begin
          e = exp_q.pop_front();
          chk("beat_res", 64'(bus.res), 64'(e.res));
          chk("beat_flags", 64'({bus.s_case, bus.flg_inv, bus.flg_inf, bus.flg_zero}), 64'(e.f));
          if (bus.cnt_clr) mcnt = '0;
          else if (e.f[3] && mcnt != 2'b11) mcnt = mcnt + 2'd1;
        end
      end else begin
        if (bus.cnt_clr) mcnt = '0;
        if (bus.out_valid) begin
          if (held_v)
            chk("stall_hold", 64'({bus.res, bus.s_case, bus.flg_inv, bus.flg_inf, bus.flg_zero}),
                64'(held));
          held_v = 1;
          held   = {bus.res, bus.s_case, bus.flg_inv, bus.flg_inf, bus.flg_zero};
        end else begin
          held_v = 0;
        end
      end
    end
  end

  localparam logic [31:0] QN = 32'h7FC00000;

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_res", 64'(bus.res), 64'd0);
    chk("rst_flags", 64'({bus.s_case, bus.flg_inv, bus.flg_inf, bus.flg_zero}), 64'd0);
    chk("rst_spc_cnt", 64'(bus.spc_cnt), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // directed vectors, back to back
    send(32'h7F800000, 32'hFF800000, 2'b00, QN,           4'b1100); // +inf + -inf
    send(32'h7F800000, 32'h00000000, 2'b10, QN,           4'b1100); // inf * 0
    send(32'h7F800000, 32'h00000000, 2'b00, 32'h7F800000, 4'b1010); // inf + 0
    send(32'h80000000, 32'h80000000, 2'b00, 32'h80000000, 4'b1001); // -0 + -0
    send(32'h80000000, 32'h80000000, 2'b01, 32'h00000000, 4'b1001); // -0 - -0
    send(32'h3F800000, 32'h40000000, 2'b00, 32'h00000000, 4'b0000); // ordinary
    send(32'h00000001, 32'h3F800000, 2'b00, 32'h3F800000, 4'b1000); // FTZ subnormal
    send(32'h7F800001, 32'h3F800000, 2'b00, QN,           4'b1100); // sNaN
    send(32'h7FC00001, 32'h3F800000, 2'b10, QN,           4'b1000); // qNaN mul
    send(32'h3F800000, 32'h3F800000, 2'b11, QN,           4'b1100); // reserved op
    send(32'hFF800000, 32'h40000000, 2'b10, 32'hFF800000, 4'b1010); // -inf * 2
    send(32'h80000000, 32'h3F800000, 2'b10, 32'h80000000, 4'b1001); // -0 * 1
    send(32'h3F800000, 32'h00000000, 2'b01, 32'h3F800000, 4'b1000); // 1 - 0
    send(32'h00000000, 32'h3F800000, 2'b01, 32'hBF800000, 4'b1000); // 0 - 1
    send(32'h7F800000, 32'h7F800000, 2'b01, QN,           4'b1100); // inf - inf
    send(32'h7F800000, 32'h7F800000, 2'b00, 32'h7F800000, 4'b1010); // inf + inf
    send(32'h3F800000, 32'hFF800000, 2'b01, 32'h7F800000, 4'b1010); // 1 - (-inf)
    send(32'h40000000, 32'h40400000, 2'b10, 32'h00000000, 4'b0000); // ordinary mul
    drain();

    // backpressure: two beats fill the pipe, then in_ready must drop
    bus.out_ready = 1'b0;
    send(32'h7F800000, 32'h00000000, 2'b10, QN,           4'b1100);
    send(32'h00000000, 32'h40000000, 2'b00, 32'h40000000, 4'b1000);
    @(negedge clk);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    fork
      begin
        send(32'h3F800000, 32'h40000000, 2'b00, 32'h00000000, 4'b0000);
        send(32'hFF800000, 32'h80000000, 2'b00, 32'hFF800000, 4'b1010);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // counter: clear, then saturation at 3
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1 bus.cnt_clr = 1'b0;
    chk("cnt_clr_idle", 64'(bus.spc_cnt), 64'd0);
    for (int i = 0; i < 5; i++)
      send(32'h00000000, 32'h00000000, 2'b10, 32'h00000000, 4'b1001);
    drain();
    chk("cnt_sat", 64'(bus.spc_cnt), 64'd3);

    // clear coincident with a delivered special beat
    send(32'h7F800000, 32'h00000000, 2'b00, 32'h7F800000, 4'b1010);
    @(posedge clk); #1;
    chk("clr_beat_valid", 64'(bus.out_valid), 64'd1);
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1 bus.cnt_clr = 1'b0;
    chk("clr_with_beat", 64'(bus.spc_cnt), 64'd0);

    // reset mid-stream
    send(32'h3F800000, 32'h3F800000, 2'b11, QN, 4'b1100);
    send(32'h3F800000, 32'h3F800000, 2'b11, QN, 4'b1100);
    send(32'h3F800000, 32'h3F800000, 2'b11, QN, 4'b1100);
    chk("pre_rst_cnt", 64'(bus.spc_cnt), 64'd1);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_spc_cnt", 64'(bus.spc_cnt), 64'd0);
    chk("mid_rst_res", 64'(bus.res), 64'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    send(32'h3F800000, 32'h00000000, 2'b01, 32'h3F800000, 4'b1000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
